// File: rtl/ifetch_req_ctrl_pkg.sv
// Shared definitions for the instruction-fetch request controller:
// FSM state encoding, default reset PC and redirect-source priority.
package ifetch_req_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_REDIR = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] IFETCH_RESET_PC = 32'h1c00_0000;

   // Redirect sources, lower index wins.
   localparam int REDIR_IDX_EXCEP  = 0;
   localparam int REDIR_IDX_ERTN   = 1;
   localparam int REDIR_IDX_TLB    = 2;
   localparam int REDIR_IDX_BRANCH = 3;
   localparam int REDIR_NUM        = 4;

   // Returns the index of the highest-priority asserted redirect source.
   function automatic logic [1:0] redir_select(input logic [REDIR_NUM-1:0] en);
      logic [1:0] sel;
      sel = 2'(REDIR_IDX_BRANCH);
      for (int i = REDIR_NUM - 1; i >= 0; i--) begin
         if (en[i]) sel = 2'(i);
      end
      return sel;
   endfunction

endpackage

// File: rtl/ifetch_pc_fifo.sv
// Small synchronous FIFO that tags each accepted fetch request with its PC.
// Clear has priority over push/pop; push and pop in one cycle keep the count.
module ifetch_pc_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop_i && (count_q != '0);
      do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ifetch_req_ctrl.sv
// Instruction-fetch request controller: owns the fetch PC, arbitrates
// redirects, bounds outstanding SRAM requests and discards responses to
// requests issued before a redirect.
// Optional build macro IFETCH_PERF_CNT_EN adds cancel/stall perf counters.
module ifetch_req_ctrl
   import ifetch_req_ctrl_pkg::*;
#(
   parameter int             PC_W            = 32,
   parameter int             MAX_OUTSTANDING = 2,
   parameter logic [PC_W-1:0] RESET_PC       = PC_W'(IFETCH_RESET_PC),
   localparam int            CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_error_i,
   input  logic             next_allowin_i,
   input  logic             excep_en_i,
   input  logic [PC_W-1:0]  excep_pc_i,
   input  logic             ertn_en_i,
   input  logic [PC_W-1:0]  ertn_pc_i,
   input  logic             tlb_flush_en_i,
   input  logic [PC_W-1:0]  tlb_flush_pc_i,
   input  logic             branch_en_i,
   input  logic [PC_W-1:0]  branch_pc_i,
   output logic             inst_sram_req_o,
   output logic [PC_W-1:0]  inst_sram_addr_o,
   input  logic             inst_sram_addr_ok_i,
   input  logic             inst_sram_data_ok_i,
   input  logic [31:0]      inst_sram_rdata_i,
   output logic             resp_valid_o,
   output logic [PC_W-1:0]  resp_pc_o,
   output logic [31:0]      resp_inst_o,
`ifdef IFETCH_PERF_CNT_EN
   output logic [31:0]      perf_cancel_o,
   output logic [31:0]      perf_stall_o,
`endif
   output logic [CNT_W-1:0] inflight_o
);

   fetch_state_e            state_q, state_d;
   logic [PC_W-1:0]         fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]        cancel_cnt_q, cancel_cnt_d;
   logic [CNT_W-1:0]        fifo_cnt;
   logic [PC_W-1:0]         fifo_head;
   logic                    fifo_clear;
   logic                    fifo_pop;
   logic [REDIR_NUM-1:0]    redir_en_vec;
   logic [PC_W-1:0]         redir_pc_vec [REDIR_NUM];
   logic [PC_W-1:0]         redir_target;
   logic                    redir_any;
   logic                    redir_take;
   logic                    halted;
   logic [CNT_W-1:0]        inflight;
   logic                    below_limit;
   logic                    req;
   logic                    accept;
   logic                    resp_valid;

   assign redir_en_vec[REDIR_IDX_EXCEP]  = excep_en_i;
   assign redir_en_vec[REDIR_IDX_ERTN]   = ertn_en_i;
   assign redir_en_vec[REDIR_IDX_TLB]    = tlb_flush_en_i;
   assign redir_en_vec[REDIR_IDX_BRANCH] = branch_en_i;
   assign redir_pc_vec[REDIR_IDX_EXCEP]  = excep_pc_i;
   assign redir_pc_vec[REDIR_IDX_ERTN]   = ertn_pc_i;
   assign redir_pc_vec[REDIR_IDX_TLB]    = tlb_flush_pc_i;
   assign redir_pc_vec[REDIR_IDX_BRANCH] = branch_pc_i;

   assign redir_any    = |redir_en_vec;
   assign redir_target = redir_pc_vec[redir_select(redir_en_vec)];
   assign halted       = (state_q == ST_HALT);
   // A CPU error in the same cycle as a redirect wins; fetch stops for good.
   assign redir_take   = redir_any && !halted && !cpu_error_i;
   assign inflight     = fifo_cnt + cancel_cnt_q;
   assign below_limit  = (inflight < CNT_W'(MAX_OUTSTANDING));
   assign req          = !halted && next_allowin_i && !redir_any && !cpu_error_i && below_limit;
   assign accept       = req && inst_sram_addr_ok_i;

   // Next-state: FSM, fetch PC, cancel counter and response routing.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      cancel_cnt_d = cancel_cnt_q;
      fifo_clear   = 1'b0;
      fifo_pop     = 1'b0;
      resp_valid   = 1'b0;

      if (!halted) begin
         if (cpu_error_i) begin
            state_d = ST_HALT;
         end else if (redir_any) begin
            state_d    = ST_REDIR;
            fetch_pc_d = redir_target;
         end else if (accept) begin
            state_d    = ST_RUN;
            fetch_pc_d = fetch_pc_q + PC_W'(4);
         end
      end

      if (redir_take) begin
         fifo_clear = 1'b1;
         if (inst_sram_data_ok_i && (inflight != '0)) begin
            cancel_cnt_d = inflight - 1'b1;
         end else begin
            cancel_cnt_d = inflight;
         end
      end else if (inst_sram_data_ok_i) begin
         if (cancel_cnt_q != '0) begin
            cancel_cnt_d = cancel_cnt_q - 1'b1;
         end else if (fifo_cnt != '0) begin
            fifo_pop   = 1'b1;
            resp_valid = !halted;
         end
      end
   end

   // Controller state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         fetch_pc_q   <= RESET_PC;
         cancel_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         cancel_cnt_q <= cancel_cnt_d;
      end
   end

   ifetch_pc_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (PC_W)
   ) u_pc_fifo (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (fifo_clear),
      .push_i      (accept),
      .push_data_i (fetch_pc_q),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .count_o     (fifo_cnt)
   );

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_cancel_q, perf_cancel_d;
   logic [31:0] perf_stall_q, perf_stall_d;
   logic        drop_event;
   logic        stall_event;

   assign drop_event  = inst_sram_data_ok_i && (inflight != '0) && !resp_valid;
   assign stall_event = next_allowin_i && !below_limit && !halted && !redir_any && !cpu_error_i;

   // Saturating perf counter increments.
   always_comb begin
      perf_cancel_d = perf_cancel_q;
      perf_stall_d  = perf_stall_q;
      if (drop_event && (perf_cancel_q != 32'hFFFF_FFFF)) perf_cancel_d = perf_cancel_q + 32'd1;
      if (stall_event && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_d = perf_stall_q + 32'd1;
   end

   // Perf counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cancel_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_cancel_q <= perf_cancel_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_cancel_o = perf_cancel_q;
   assign perf_stall_o  = perf_stall_q;
`endif

   assign inst_sram_req_o  = req;
   assign inst_sram_addr_o = fetch_pc_q;
   assign resp_valid_o     = resp_valid;
   assign resp_pc_o        = resp_valid ? fifo_head : '0;
   assign resp_inst_o      = resp_valid ? inst_sram_rdata_i : 32'd0;
   assign inflight_o       = inflight;

endmodule

// File: tb/tb_ifetch_req_ctrl.sv
// Directed self-checking bench for ifetch_req_ctrl (default parameters).
module tb_ifetch_req_ctrl;

   logic        clk;
   logic        rst;
   logic        cpu_error;
   logic        next_allowin;
   logic        excep_en, ertn_en, tlb_flush_en, branch_en;
   logic [31:0] excep_pc, ertn_pc, tlb_flush_pc, branch_pc;
   logic        req;
   logic [31:0] addr;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        resp_valid;
   logic [31:0] resp_pc;
   logic [31:0] resp_inst;
   logic [1:0]  inflight;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_cancel;
   logic [31:0] perf_stall;
`endif

   int check_count = 0;
   int error_count = 0;

   ifetch_req_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .cpu_error_i         (cpu_error),
      .next_allowin_i      (next_allowin),
      .excep_en_i          (excep_en),
      .excep_pc_i          (excep_pc),
      .ertn_en_i           (ertn_en),
      .ertn_pc_i           (ertn_pc),
      .tlb_flush_en_i      (tlb_flush_en),
      .tlb_flush_pc_i      (tlb_flush_pc),
      .branch_en_i         (branch_en),
      .branch_pc_i         (branch_pc),
      .inst_sram_req_o     (req),
      .inst_sram_addr_o    (addr),
      .inst_sram_addr_ok_i (addr_ok),
      .inst_sram_data_ok_i (data_ok),
      .inst_sram_rdata_i   (rdata),
      .resp_valid_o        (resp_valid),
      .resp_pc_o           (resp_pc),
      .resp_inst_o         (resp_inst),
`ifdef IFETCH_PERF_CNT_EN
      .perf_cancel_o       (perf_cancel),
      .perf_stall_o        (perf_stall),
`endif
      .inflight_o          (inflight)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the per-cycle handshake inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic allowin, input logic aok, input logic dok,
                                input logic [31:0] data);
      next_allowin = allowin;
      addr_ok      = aok;
      data_ok      = dok;
      rdata        = data;
      #2;
   endtask

   task automatic clearRedirects();
      excep_en     = 1'b0;
      ertn_en      = 1'b0;
      tlb_flush_en = 1'b0;
      branch_en    = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Count one comparison and report it if it does not hold.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Main directed sequence.
   initial begin
      rst          = 1'b1;
      cpu_error    = 1'b0;
      clearRedirects();
      excep_pc     = 32'h0;
      ertn_pc      = 32'h0;
      tlb_flush_pc = 32'h0;
      branch_pc    = 32'h0;

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("rst_req", 32'(req), 32'd0);
      checkOutput("rst_addr", addr, 32'h1c00_0000);
      checkOutput("rst_inflight", 32'(inflight), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_pc", resp_pc, 32'd0);
      checkOutput("rst_resp_inst", resp_inst, 32'd0);
      nextCycle();
      rst = 1'b0;

      // Sequential fetch with data_ok one cycle after addr_ok
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("seq_req0", 32'(req), 32'd1);
      checkOutput("seq_addr0", addr, 32'h1c00_0000);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hAAAA_0000);
      checkOutput("seq_addr1", addr, 32'h1c00_0004);
      checkOutput("seq_valid0", 32'(resp_valid), 32'd1);
      checkOutput("seq_rpc0", resp_pc, 32'h1c00_0000);
      checkOutput("seq_inst0", resp_inst, 32'hAAAA_0000);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hAAAA_0001);
      checkOutput("seq_addr2", addr, 32'h1c00_0008);
      checkOutput("seq_rpc1", resp_pc, 32'h1c00_0004);
      checkOutput("seq_inflight", 32'(inflight), 32'd1);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hAAAA_0002);
      checkOutput("seq_rpc2", resp_pc, 32'h1c00_0008);
      checkOutput("seq_req3", 32'(req), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("seq_noallow_req", 32'(req), 32'd0);
      checkOutput("seq_drained", 32'(inflight), 32'd0);

      // Address held stable while addr_ok is low
      nextCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
         checkOutput("stall_req", 32'(req), 32'd1);
         checkOutput("stall_addr", addr, 32'h1c00_000c);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("stall_accept_addr", addr, 32'h1c00_000c);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_pc_adv", addr, 32'h1c00_0010);
      checkOutput("stall_inflight", 32'(inflight), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hBBBB_0000);
      checkOutput("stall_rpc", resp_pc, 32'h1c00_000c);
      nextCycle();

      // Branch redirect cancels two outstanding requests
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("br_addr0", addr, 32'h1c00_0010);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("br_addr1", addr, 32'h1c00_0014);
      nextCycle();
      branch_en = 1'b1;
      branch_pc = 32'h1c00_0100;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("br_bubble_req", 32'(req), 32'd0);
      checkOutput("br_inflight", 32'(inflight), 32'd2);
      nextCycle();
      clearRedirects();
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hCCCC_0000);
      checkOutput("br_drop0_valid", 32'(resp_valid), 32'd0);
      checkOutput("br_full_req", 32'(req), 32'd0);
      checkOutput("br_target", addr, 32'h1c00_0100);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hCCCC_0001);
      checkOutput("br_drop1_valid", 32'(resp_valid), 32'd0);
      checkOutput("br_req_target", 32'(req), 32'd1);
      checkOutput("br_inflight1", 32'(inflight), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678);
      checkOutput("br_live_valid", 32'(resp_valid), 32'd1);
      checkOutput("br_live_rpc", resp_pc, 32'h1c00_0100);
      checkOutput("br_live_inst", resp_inst, 32'h1234_5678);
      nextCycle();

      // Priority: excep over branch, then ertn overwrites pending target
      excep_en  = 1'b1;
      excep_pc  = 32'h1c00_0800;
      branch_en = 1'b1;
      branch_pc = 32'h1c00_0100;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("prio_req", 32'(req), 32'd0);
      nextCycle();
      clearRedirects();
      ertn_en = 1'b1;
      ertn_pc = 32'h1c00_0200;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("prio_excep_pc", addr, 32'h1c00_0800);
      nextCycle();
      clearRedirects();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("prio_ertn_req", 32'(req), 32'd1);
      checkOutput("prio_ertn_addr", addr, 32'h1c00_0200);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hDDDD_0000);
      checkOutput("prio_ertn_rpc", resp_pc, 32'h1c00_0200);
      nextCycle();
      tlb_flush_en = 1'b1;
      tlb_flush_pc = 32'h1c00_0300;
      branch_en    = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      nextCycle();
      clearRedirects();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("prio_tlb_pc", addr, 32'h1c00_0300);
      nextCycle();

      // Outstanding limit
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("lim_addr0", addr, 32'h1c00_0300);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("lim_addr1", addr, 32'h1c00_0304);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("lim_full_req", 32'(req), 32'd0);
      checkOutput("lim_full_inflight", 32'(inflight), 32'd2);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hEEEE_0000);
      checkOutput("lim_dok_req", 32'(req), 32'd0);
      checkOutput("lim_rpc0", resp_pc, 32'h1c00_0300);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("lim_resume_req", 32'(req), 32'd1);
      checkOutput("lim_resume_addr", addr, 32'h1c00_0308);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hEEEE_0001);
      checkOutput("lim_rpc1", resp_pc, 32'h1c00_0304);
      nextCycle();

      // CPU error halts fetch; outstanding response is swallowed
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("halt_pre_req", 32'(req), 32'd1);
      nextCycle();
      cpu_error = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("halt_err_req", 32'(req), 32'd0);
      nextCycle();
      cpu_error = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("halt_stays", 32'(req), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_0000);
      checkOutput("halt_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("halt_resp_pc", resp_pc, 32'd0);
      nextCycle();
      branch_en = 1'b1;
      branch_pc = 32'h1c00_0900;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("halt_inflight", 32'(inflight), 32'd0);
      nextCycle();
      clearRedirects();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("halt_no_redir", addr, 32'h1c00_030c);
      checkOutput("halt_req_after", 32'(req), 32'd0);
      nextCycle();

      // Mid-run reset, then same-cycle data_ok with a redirect
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("rst2_addr", addr, 32'h1c00_0000);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("rst2_req", 32'(req), 32'd1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("same_addr1", addr, 32'h1c00_0004);
      nextCycle();
      branch_en = 1'b1;
      branch_pc = 32'h1c00_0100;
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h1111_0000);
      checkOutput("same_drop_valid", 32'(resp_valid), 32'd0);
      nextCycle();
      clearRedirects();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("same_cancel_cnt", 32'(inflight), 32'd1);
      checkOutput("same_req_target", 32'(req), 32'd1);
      checkOutput("same_addr_target", addr, 32'h1c00_0100);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h2222_0000);
      checkOutput("same_old_first", 32'(resp_valid), 32'd0);
      checkOutput("same_inflight2", 32'(inflight), 32'd2);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h3333_0000);
      checkOutput("same_live_rpc", resp_pc, 32'h1c00_0100);
      checkOutput("same_live_inst", resp_inst, 32'h3333_0000);
      nextCycle();

      // PC wrap and spurious data_ok
      branch_en = 1'b1;
      branch_pc = 32'hFFFF_FFFC;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      nextCycle();
      clearRedirects();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("wrap_addr", addr, 32'hFFFF_FFFC);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("wrap_next", addr, 32'h0000_0000);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h4444_0000);
      checkOutput("wrap_rpc", resp_pc, 32'hFFFF_FFFC);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h5555_0000);
      checkOutput("spurious_valid", 32'(resp_valid), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("spurious_inflight", 32'(inflight), 32'd0);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/ifetch_req_ctrl.md
# ifetch_req_ctrl

Instruction-fetch request controller between the backend redirect sources (exception, ertn, TLB refetch, branch) and the instruction SRAM req/addr_ok/data_ok interface. It owns the fetch PC and arbitrates redirect targets. It bounds in-flight requests and tags each with its PC through a small FIFO. Responses belonging to requests issued before a redirect are discarded, so the IF stage only ever sees live instructions.

## Interface
- PC_W, 32, PC/address width
- MAX_OUTSTANDING, 2, max requests accepted (addr_ok) but not yet returned (data_ok), cancelled ones included; ≥1
- RESET_PC, 32'h1c00_0000, fetch PC after reset

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cpu_error_i  in  1  fatal CPU error; stop fetching permanently
- next_allowin_i  in  1  IF stage can take a new request
- excep_en_i / excep_pc_i  in  1 / PC_W  exception redirect
- ertn_en_i / ertn_pc_i  in  1 / PC_W  ertn redirect
- tlb_flush_en_i / tlb_flush_pc_i  in  1 / PC_W  TLB-op refetch redirect
- branch_en_i / branch_pc_i  in  1 / PC_W  branch redirect
- inst_sram_req_o  out  1  fetch request
- inst_sram_addr_o  out  PC_W  fetch address (= fetch_pc)
- inst_sram_addr_ok_i  in  1  request accepted
- inst_sram_data_ok_i  in  1  response valid
- inst_sram_rdata_i  in  32  response instruction
- resp_valid_o  out  1  live response to IF stage
- resp_pc_o  out  PC_W  PC of live response
- resp_inst_o  out  32  instruction of live response
- inflight_o  out  $clog2(MAX_OUTSTANDING+1)  fifo_cnt + cancel_cnt

## Operation
- Redirect priority: excep > ertn > tlb_flush > branch. redir_any = OR of the four enables.
- State machine:
  - RUN: sequential fetch.
  - REDIR: redirect target loaded, first request not yet accepted.
  - HALT: no requests.
- inst_sram_req_o is asserted when all of the following hold:
  - state != HALT
  - next_allowin_i
  - !redir_any
  - !cpu_error_i
  - inflight < MAX_OUTSTANDING
- Address stability: while req is high without addr_ok, fetch_pc holds. The only ways the request is withdrawn are a redirect or loss of allowin.
- req & addr_ok:
  - Push fetch_pc into the PC FIFO.
  - fetch_pc <= fetch_pc + 4 (mod 2^PC_W).
  - REDIR -> RUN.
- redir_any:
  - fetch_pc <= winning target.
  - state -> REDIR (from RUN or REDIR).
  - PC FIFO cleared.
  - cancel_cnt <= cancel_cnt + fifo_cnt − (data_ok ? 1 : 0).
  - A redirect arriving in REDIR overwrites the pending target.
- data_ok, three cases:
  - cancel_cnt > 0: drop; cancel_cnt − 1; resp_valid_o = 0.
  - Otherwise, if fifo_cnt > 0: pop. resp_valid_o = 1, resp_pc_o = FIFO head, resp_inst_o = rdata.
  - Otherwise (protocol violation): ignored, no counter underflow.
- Same-cycle data_ok with a redirect: the returning response is dropped. It is excluded from the new cancel_cnt. Cancelled responses always drain oldest first, before any response issued after the redirect.
- cpu_error_i: HALT entered next edge, req low the same cycle.
  - In HALT, responses are never presented. data_ok decrements cancel_cnt first, then fifo_cnt.
  - HALT exits only on rst.
- IF accepts every live response unconditionally; allowin was checked at request time.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, state = RUN.
  - fifo_cnt = cancel_cnt = 0, so inflight_o = 0.
  - inst_sram_req_o = 0, resp_valid_o = 0, resp_pc_o = 0, resp_inst_o = 0.
- First request: in the first cycle after rst deasserts, if next_allowin_i = 1.
- Request outputs are combinational from registered state plus current inputs.
- Response outputs are combinational, in the same cycle as data_ok; zero added latency.
- Redirect cycle issues no request. The target is requested in the next cycle at the earliest (1-cycle redirect bubble).
- Back-to-back: one request per cycle while not full. Push and pop in the same cycle keep fifo_cnt unchanged.
- rst mid-operation: all state cleared immediately. Outstanding memory responses are the environment's responsibility.

## Configuration
- IFETCH_PERF_CNT_EN: adds perf_cancel_o[31:0] and perf_stall_o[31:0], both 0 at reset, saturating at 32'hFFFF_FFFF.
  - perf_cancel_o counts dropped responses.
  - perf_stall_o counts cycles with next_allowin_i = 1 but req low because of the outstanding limit.
- Without the macro, neither port nor the counters exist.

## Structure
- Shared package/header holds:
  - state encoding (RUN=2'd0, REDIR=2'd1, HALT=2'd2)
  - RESET_PC default
  - redirect priority constants
- Sub-module ifetch_pc_fifo: synchronous FIFO, depth MAX_OUTSTANDING, width PC_W, with push/pop/clear/count and same-cycle push+pop support.

## Test plan
- Reset release, allowin=1, addr_ok every cycle, data_ok one cycle later -> addresses 1c000000, 1c000004, 1c000008; resp_pc_o matches each in order.
- addr_ok held low 3 cycles -> req stays high, addr stable at 1c000000; fetch_pc advances only on the addr_ok cycle.
- Two requests accepted, branch_en (pc 1c000100) before either data_ok -> both responses dropped (resp_valid_o = 0); next live response has resp_pc_o = 1c000100.
- excep_en (1c000800) and branch_en (1c000100) in the same cycle, then ertn_en (1c000200) while in REDIR -> first request is to 1c000200.
- data_ok delayed with MAX_OUTSTANDING=2 -> req low after two accepts, inflight_o = 2; req resumes the cycle after data_ok.
- cpu_error_i with one request outstanding -> req low that cycle, state HALT; the later data_ok gives resp_valid_o = 0 and inflight_o = 0.
